// File: rtl/sata_tx_align_inserter_if.sv
// Link-layer payload handshake into the SATA TX ALIGN inserter.
// Transfer happens on a cycle where i_val and o_rdy are both high.
interface sata_tx_align_inserter_if;
    logic [31:0] i_dat;
    logic [3:0]  i_datk;
    logic        i_val;
    logic        o_rdy;

    modport master (
        output i_dat,
        output i_datk,
        output i_val,
        input  o_rdy
    );

    modport slave (
        input  i_dat,
        input  i_datk,
        input  i_val,
        output o_rdy
    );
endinterface

// File: rtl/sata_tx_align_inserter.sv
// SATA TX ALIGN inserter: emits an ALIGN pair every ALIGN_PERIOD DWORDs,
// fills the remaining slots with link payload or SYNC when none is offered.
module sata_tx_align_inserter #(
    parameter int ALIGN_PERIOD = 256
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      enable,
    sata_tx_align_inserter_if.slave   lnk,
    output logic [31:0]               tx_data,
    output logic [3:0]                tx_datak,
    output logic                      tx_elecidle,
    output logic                      align_sent
);

    localparam int CW = $clog2(ALIGN_PERIOD);
    localparam logic [CW-1:0] CNT_LAST = CW'(ALIGN_PERIOD - 3);

    localparam logic [31:0] ALIGN_DW = 32'h7B4A4ABC;
    localparam logic [31:0] SYNC_DW  = 32'hB5B5957C;
    localparam logic [3:0]  K_BYTE0  = 4'b0001;

    typedef enum logic [1:0] {
        OFF,
        ALIGN_A,
        ALIGN_B,
        PAYLOAD
    } state_t;

    state_t        state;
    state_t        state_nxt;
    logic [CW-1:0] cnt;

    logic [31:0]   slot_data;
    logic [3:0]    slot_datak;
    logic          slot_idle;
    logic          slot_align;

    // State register; reset always returns to OFF.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= OFF;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state: enable low wins, otherwise walk the ALIGN/payload cycle.
    always_comb begin
        state_nxt = state;
        if (!enable) begin
            state_nxt = OFF;
        end else begin
            unique case (state)
                OFF:     state_nxt = ALIGN_A;
                ALIGN_A: state_nxt = ALIGN_B;
                ALIGN_B: state_nxt = PAYLOAD;
                PAYLOAD: begin
                    if (cnt == CNT_LAST) begin
                        state_nxt = ALIGN_A;
                    end
                end
                default: state_nxt = OFF;
            endcase
        end
    end

    // Payload slot counter; zero outside PAYLOAD, saturates at the last slot.
    always_ff @(posedge clk) begin
        if (reset || state_nxt != PAYLOAD) begin
            cnt <= '0;
        end else if (state == PAYLOAD && cnt != CNT_LAST) begin
            cnt <= cnt + CW'(1);
        end
    end

    // Slot contents for the state being generated this cycle.
    always_comb begin
        slot_data  = '0;
        slot_datak = '0;
        slot_idle  = 1'b1;
        slot_align = 1'b0;
        if (enable) begin
            unique case (state)
                OFF: begin
                    slot_idle = 1'b1;
                end
                ALIGN_A: begin
                    slot_data  = ALIGN_DW;
                    slot_datak = K_BYTE0;
                    slot_idle  = 1'b0;
                end
                ALIGN_B: begin
                    slot_data  = ALIGN_DW;
                    slot_datak = K_BYTE0;
                    slot_idle  = 1'b0;
                    slot_align = 1'b1;
                end
                PAYLOAD: begin
                    slot_idle = 1'b0;
                    if (lnk.i_val) begin
                        slot_data  = lnk.i_dat;
                        slot_datak = lnk.i_datk;
                    end else begin
                        slot_data  = SYNC_DW;
                        slot_datak = K_BYTE0;
                    end
                end
                default: slot_idle = 1'b1;
            endcase
        end
    end

    // Transceiver-facing outputs are registered one cycle behind the slot.
    always_ff @(posedge clk) begin
        if (reset) begin
            tx_data     <= '0;
            tx_datak    <= '0;
            tx_elecidle <= 1'b1;
            align_sent  <= 1'b0;
        end else begin
            tx_data     <= slot_data;
            tx_datak    <= slot_datak;
            tx_elecidle <= slot_idle;
            align_sent  <= slot_align;
        end
    end

    // Payload acceptance only in PAYLOAD slots, masked during reset.
    always_comb begin
        lnk.o_rdy = enable && !reset && (state == PAYLOAD);
    end

endmodule

// File: tb/tb_sata_tx_align_inserter.sv
// Self-checking bench for sata_tx_align_inserter with ALIGN_PERIOD = 8.
// Reference model tracks the position inside the ALIGN period as an integer.
module tb_sata_tx_align_inserter;

    localparam int P = 8;
    localparam logic [31:0] ALIGN_DW = 32'h7B4A4ABC;
    localparam logic [31:0] SYNC_DW  = 32'hB5B5957C;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        enable = 1'b1;
    logic [31:0] tx_data;
    logic [3:0]  tx_datak;
    logic        tx_elecidle;
    logic        align_sent;

    sata_tx_align_inserter_if lnk ();

    sata_tx_align_inserter #(.ALIGN_PERIOD(P)) dut (
        .clk         (clk),
        .reset       (reset),
        .enable      (enable),
        .lnk         (lnk.slave),
        .tx_data     (tx_data),
        .tx_datak    (tx_datak),
        .tx_elecidle (tx_elecidle),
        .align_sent  (align_sent)
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_pass = 0;

    // Model: pos = -1 when off, else slot index within the period
    // (0,1 = ALIGN pair, 2..P-1 = payload).
    int          pos = -1;
    logic [31:0] e_data = '0;
    logic [3:0]  e_datk = '0;
    logic        e_idle = 1'b1;
    logic        e_as   = 1'b0;
    logic        acc;
    int          n_acc;

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        n_chk++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h expected %0h at %0t",
                     tag, got, exp, $time);
        end
    endtask

    // One clock: inputs already driven by caller at the negedge.
    task automatic step();
        logic exp_rdy;
        #1;
        exp_rdy = !reset && enable && (pos >= 2);
        chk("o_rdy", 64'(lnk.o_rdy), 64'(exp_rdy));
        acc = lnk.i_val && exp_rdy;
        if (reset || !enable || pos < 0) begin
            e_data = '0;
            e_datk = '0;
            e_idle = 1'b1;
            e_as   = 1'b0;
            pos    = (reset || !enable) ? -1 : 0;
        end else begin
            e_idle = 1'b0;
            e_as   = (pos == 1);
            if (pos < 2) begin
                e_data = ALIGN_DW;
                e_datk = 4'b0001;
            end else if (lnk.i_val) begin
                e_data = lnk.i_dat;
                e_datk = lnk.i_datk;
            end else begin
                e_data = SYNC_DW;
                e_datk = 4'b0001;
            end
            pos = (pos + 1) % P;
        end
        @(posedge clk);
        #1;
        chk("tx_data", 64'(tx_data), 64'(e_data));
        chk("tx_datak", 64'(tx_datak), 64'(e_datk));
        chk("tx_elecidle", 64'(tx_elecidle), 64'(e_idle));
        chk("align_sent", 64'(align_sent), 64'(e_as));
        @(negedge clk);
    endtask

    initial begin
        logic [31:0] ctr;
        lnk.i_dat  = 32'h0;
        lnk.i_datk = 4'h0;
        lnk.i_val  = 1'b1;
        @(negedge clk);

        // Reset held with enable and valid asserted: stays idle.
        for (int i = 0; i < 4; i++) step();

        // Free-running with no payload: ALIGN pair then SYNC fill.
        reset     = 1'b0;
        lnk.i_val = 1'b0;
        for (int i = 0; i < 3 * P; i++) step();

        // Continuous payload with incrementing data.
        ctr        = 32'd1;
        lnk.i_val  = 1'b1;
        lnk.i_dat  = ctr;
        n_acc      = 0;
        for (int i = 0; i < 2 * P; i++) begin
            step();
            if (acc) begin
                n_acc++;
                ctr       = ctr + 32'd1;
                lnk.i_dat = ctr;
            end
        end
        chk("xfers_per_2P", 64'(n_acc), 64'(2 * (P - 2)));

        // Randomized: held-until-accepted source, enable drops, resets.
        for (int i = 0; i < 3000; i++) begin
            if (!lnk.i_val || acc) begin
                lnk.i_val  = ($urandom_range(0, 2) != 0);
                lnk.i_dat  = $urandom;
                lnk.i_datk = 4'($urandom_range(0, 15));
            end
            enable = ($urandom_range(0, 29) != 0);
            reset  = ($urandom_range(0, 199) == 0);
            step();
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/sata_tx_align_inserter.md
SATA_TX_ALIGN_INSERTER -- requirements
Module: sata_tx_align_inserter

Interface
REQ-001 Parameter ALIGN_PERIOD, default 256, meaning DWORDs per ALIGN cycle (2 ALIGN + ALIGN_PERIOD-2 payload slots); legal range 4..1024.
REQ-002 reset  input  1  synchronous, active-high reset.
REQ-003 clk  input  1  single clock for all logic (transceiver tx_clock domain).
REQ-004 enable  input  1  link transmit enable; low forces electrical idle.
REQ-005 i_dat  input  32  payload DWORD from link layer.
REQ-006 i_datk  input  4  K-character flags for i_dat, bit n ↔ byte n.
REQ-007 i_val  input  1  i_dat/i_datk valid.
REQ-008 o_rdy  output  1  payload slot available; transfer when i_val & o_rdy.
REQ-009 tx_data  output  32  DWORD to transceiver tx_data.
REQ-010 tx_datak  output  4  K flags to transceiver tx_datak.
REQ-011 tx_elecidle  output  1  to transceiver tx_elecidle.
REQ-012 align_sent  output  1  one-cycle pulse when the second ALIGN of a pair is on tx_data.

Function
REQ-013 Constants: ALIGN = 32'h7B4A4ABC / datak 4'b0001; SYNC = 32'hB5B5957C / datak 4'b0001.
REQ-014 FSM states OFF, ALIGN_A, ALIGN_B, PAYLOAD; state names the slot being generated this cycle.
REQ-015 Transitions: OFF→ALIGN_A when enable=1; ALIGN_A→ALIGN_B; ALIGN_B→PAYLOAD; PAYLOAD→ALIGN_A after ALIGN_PERIOD-2 PAYLOAD cycles; any state→OFF when enable=0 (takes priority).
REQ-016 tx_data, tx_datak, tx_elecidle, align_sent are registered; each reflects the slot generated in the previous cycle (latency 1).
REQ-017 ALIGN_A/ALIGN_B slots load ALIGN, tx_elecidle=0.
REQ-018 PAYLOAD slot: if i_val=1 load i_dat/i_datk, else load SYNC; tx_elecidle=0.
REQ-019 OFF slot (and cycle enable=0 is sampled) loads tx_data=0, tx_datak=0, tx_elecidle=1.
REQ-020 o_rdy = enable & (state==PAYLOAD), combinational; never 1 in ALIGN_A/ALIGN_B/OFF.
REQ-021 Payload slot counter: cleared on entry to ALIGN_A; counts 0..ALIGN_PERIOD-3 in PAYLOAD; width clog2(ALIGN_PERIOD); no wrap beyond terminal value.
REQ-022 Payload slots count regardless of i_val (SYNC fills still consume the slot); ALIGN spacing never stretches.
REQ-023 enable drop mid-pair or mid-payload: no partial recovery; next enable=1 restarts with a full ALIGN pair.
REQ-024 align_sent loaded 1 with the ALIGN_B slot, 0 otherwise.
REQ-025 i_dat/i_datk content is not checked; K flags pass through unmodified.

Reset
REQ-026 On reset=1: state=OFF, counter=0, tx_data=0, tx_datak=0, tx_elecidle=1, align_sent=0; o_rdy=0 combinationally while reset=1.
REQ-027 reset takes priority over enable; first slot after reset release with enable=1 is ALIGN_A.

Verification (ALIGN_PERIOD=8)
REQ-028 Reset held, enable=1, i_val=1 -> tx_elecidle=1, tx_data=0, o_rdy=0 every cycle.
REQ-029 Release reset, enable=1, i_val=0 -> tx_data sequence from cycle+1: 7B4A4ABC, 7B4A4ABC, then 6×B5B5957C, repeating; align_sent on each second ALIGN.
REQ-030 i_val=1 continuous with incrementing i_dat from 1 -> exactly 6 transfers per 8 cycles; tx_data shows 1..6 after ALIGN pair, 7..12 after next; no data lost or duplicated.
REQ-031 enable=0 in second payload slot -> next cycle tx_elecidle=1, tx_data=0, o_rdy=0; enable=1 again -> ALIGN, ALIGN, then payload.
REQ-032 i_val toggling 1,0,1,0 during PAYLOAD -> tx_data alternates data/SYNC; counter still expires after 6 slots.
REQ-033 i_val=1 held during ALIGN_A/ALIGN_B -> o_rdy=0, i_dat held by source, transferred in first PAYLOAD slot.
